// File: rtl/pair_cfg_loader_if.sv
// -----------------------------------------------------------------------------
// pair_cfg_loader_if
// Word-serial configuration stream into the pair configuration loader.
//   cfg_valid : source has a beat on cfg_data
//   cfg_ready : loader accepts the beat (transfer when cfg_valid && cfg_ready)
//   cfg_data  : beat payload
//   cfg_last  : final beat of the image
// Modports: master = stream source, slave = loader.
// -----------------------------------------------------------------------------
interface pair_cfg_loader_if #(
    parameter int DATA_W = 32
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_last;

    modport master (output cfg_valid, output cfg_data, output cfg_last, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_data, input  cfg_last, output cfg_ready);
endinterface

// File: rtl/pair_cfg_loader.sv
// -----------------------------------------------------------------------------
// pair_cfg_loader
// Receives a word-serial configuration image, holds it in a shadow buffer and,
// when the image is clean, commits all of it to the active constant/control
// registers of one pair atom on a single clock edge.
//
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   cfg      : configuration stream (slave modport of pair_cfg_loader_if)
//   err_clr  : single-cycle pulse clearing the sticky error flags
//   cons_o   : active constants, cons_k at [32k-1:32(k-1)]
//   ctrl_o   : active control vector (selects [49:0], rel_op1..3 [55:50],
//              reserved [63:56])
//   cfg_gen  : commit counter, wraps 255 -> 0
//   busy     : FSM not in IDLE
//   err_len  : sticky, image length wrong
//   err_rsv  : sticky, reserved control bits nonzero
//   err_chk  : sticky, checksum mismatch (constant 0 unless PAIR_CFG_CHK_EN)
//
// Build option: define PAIR_CFG_CHK_EN to append a checksum word (XOR of all
// image words) and enable err_chk.
// -----------------------------------------------------------------------------
module pair_cfg_loader #(
    parameter int N_CONS   = 19,
    parameter int N_CTRL_W = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pair_cfg_loader_if.slave        cfg,
    input  logic                    err_clr,
    output logic [32*N_CONS-1:0]    cons_o,
    output logic [32*N_CTRL_W-1:0]  ctrl_o,
    output logic [7:0]              cfg_gen,
    output logic                    busy,
    output logic                    err_len,
    output logic                    err_rsv,
    output logic                    err_chk
);
    localparam int N_IMG = N_CONS + N_CTRL_W;
`ifdef PAIR_CFG_CHK_EN
    localparam int L       = N_IMG + 1;
    localparam int RSV_IDX = N_IMG - 1;
`else
    localparam int L       = N_IMG;
`endif
    localparam int              CNT_W    = $clog2(L);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(L - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [31:0]      shadow [L];
    logic [CNT_W-1:0] wr_idx;
    logic             accept;
    logic             shadow_we;
    logic             set_len;
    logic             do_commit;
    logic             final_beat;  // cfg_last on the beat that completes a full-length image
    logic             rsv_bad;
    logic             img_bad;
    logic             set_rsv;

    assign accept     = cfg.cfg_valid && cfg.cfg_ready;
    assign final_beat = accept && (state_q == LOAD) && cfg.cfg_last && (cnt_q == LAST_IDX);

    // Without a checksum the reserved control word is the final beat itself,
    // so it is checked on the bus; with a checksum it already sits in the shadow.
`ifdef PAIR_CFG_CHK_EN
    logic [31:0] chk_acc;
    logic        chk_bad;
    logic        set_chk;

    assign rsv_bad = |shadow[RSV_IDX][31:24];
    assign chk_bad = (cfg.cfg_data != chk_acc);
    assign img_bad = rsv_bad || chk_bad;
    assign set_chk = final_beat && chk_bad;
`else
    assign rsv_bad = |cfg.cfg_data[31:24];
    assign img_bad = rsv_bad;
`endif
    assign set_rsv = final_beat && rsv_bad;

    assign busy          = (state_q != IDLE);
    assign cfg.cfg_ready = (state_q != COMMIT);
    assign wr_idx        = (state_q == IDLE) ? '0 : cnt_q;

    // State and word counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        shadow_we = 1'b0;
        set_len   = 1'b0;
        do_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shadow_we = 1'b1;
                    if (cfg.cfg_last) begin
                        set_len = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n   = CNT_W'(1);
                        state_n = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    shadow_we = 1'b1;
                    cnt_n     = cnt_q + CNT_W'(1);
                    if (cfg.cfg_last) begin
                        cnt_n = '0;
                        if (cnt_q == LAST_IDX) begin
                            state_n = img_bad ? IDLE : COMMIT;
                        end else begin
                            set_len = 1'b1;
                            state_n = IDLE;
                        end
                    end else if (cnt_q == LAST_IDX) begin
                        // Image overran: flag now, swallow the rest up to cfg_last.
                        set_len = 1'b1;
                        cnt_n   = '0;
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && cfg.cfg_last) begin
                    state_n = IDLE;
                end
            end
            COMMIT: begin
                do_commit = 1'b1;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Shadow buffer: data only, a new image overwrites every word it uses
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow[wr_idx] <= cfg.cfg_data;
        end
    end

`ifdef PAIR_CFG_CHK_EN
    // Running XOR of the image words; at the checksum beat it covers words 0..L-2
    always_ff @(posedge clk) begin
        if (accept && (state_q == IDLE)) begin
            chk_acc <= cfg.cfg_data;
        end else if (accept && (state_q == LOAD)) begin
            chk_acc <= chk_acc ^ cfg.cfg_data;
        end
    end
`endif

    // Active registers: only COMMIT touches them, so the atom sees one atomic update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cons_o  <= '0;
            ctrl_o  <= '0;
            cfg_gen <= '0;
        end else if (do_commit) begin
            for (int k = 0; k < N_CONS; k++) begin
                cons_o[32*k +: 32] <= shadow[k];
            end
            for (int j = 0; j < N_CTRL_W; j++) begin
                ctrl_o[32*j +: 32] <= shadow[N_CONS + j];
            end
            cfg_gen <= cfg_gen + 8'd1;
        end
    end

    // Sticky error flags: a new error on the clearing edge takes priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_len <= 1'b0;
            err_rsv <= 1'b0;
        end else begin
            err_len <= (err_len && !err_clr) || set_len;
            err_rsv <= (err_rsv && !err_clr) || set_rsv;
        end
    end

`ifdef PAIR_CFG_CHK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_chk <= 1'b0;
        end else begin
            err_chk <= (err_chk && !err_clr) || set_chk;
        end
    end
`else
    assign err_chk = 1'b0;
`endif

endmodule

// File: tb/tb_pair_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_pair_cfg_loader
// Directed, table-driven bench for pair_cfg_loader: a table of image scenarios
// with hand-stated outcomes, plus sequences for error-clear priority, reset in
// the middle of an image and commit-counter wrap.
// -----------------------------------------------------------------------------
module tb_pair_cfg_loader;
    localparam int N_CONS   = 19;
    localparam int N_CTRL_W = 2;
`ifdef PAIR_CFG_CHK_EN
    localparam int L = 22;
`else
    localparam int L = 21;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         err_clr = 1'b0;
    logic [607:0] cons_o;
    logic [63:0]  ctrl_o;
    logic [7:0]   cfg_gen;
    logic         busy;
    logic         err_len;
    logic         err_rsv;
    logic         err_chk;

    pair_cfg_loader_if cfg_if ();

    pair_cfg_loader #(
        .N_CONS   (N_CONS),
        .N_CTRL_W (N_CTRL_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cfg     (cfg_if),
        .err_clr (err_clr),
        .cons_o  (cons_o),
        .ctrl_o  (ctrl_o),
        .cfg_gen (cfg_gen),
        .busy    (busy),
        .err_len (err_len),
        .err_rsv (err_rsv),
        .err_chk (err_chk)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the active registers
    logic [31:0] exp_cons [N_CONS];
    logic [63:0] exp_ctrl;
    logic [7:0]  exp_gen;

    typedef struct {
        string       name;
        int          nbeats;
        logic [31:0] base;
        logic [31:0] w19;
        logic [31:0] w20;
        bit          commit;
        bit          elen;
        bit          ersv;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [607:0] act, input logic [607:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [607:0] exp_cons_flat();
        logic [607:0] f;
        for (int k = 0; k < N_CONS; k++) f[32*k +: 32] = exp_cons[k];
        return f;
    endfunction

    function automatic logic [31:0] img_word(input int i, input logic [31:0] base,
                                             input logic [31:0] w19, input logic [31:0] w20,
                                             input logic [31:0] cks);
        if (i < 19)       return base + 32'(i + 1);
        else if (i == 19) return w19;
        else if (i == 20) return w20;
        else if (i == 21 && L == 22) return cks;
        else              return 32'hA5A5_0000 | 32'(i);
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic put_beat(input logic [31:0] d, input logic l, input logic clr);
        int   n = 0;
        logic r;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = d;
        cfg_if.cfg_last  = l;
        err_clr          = clr;
        forever begin
            r = cfg_if.cfg_ready;
            @(posedge clk);
            n++;
            if (r) break;
            if (n > 8) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat_accept_timeout: cfg_ready stayed 0 for %0d cycles, expected 1", n);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_last  = 1'b0;
        err_clr          = 1'b0;
    endtask

    task automatic send_image(input string name, input int nbeats, input logic [31:0] base,
                              input logic [31:0] w19, input logic [31:0] w20, input bit clr_last,
                              input bit commit, input bit elen, input bit ersv);
        logic [31:0] x = '0;
        logic [7:0]  gen_before = exp_gen;
        for (int i = 0; i < nbeats; i++) begin
            logic [31:0] w;
            w = img_word(i, base, w19, w20, x);
            if (i < 21) x = x ^ w;
            put_beat(w, (i == nbeats - 1), clr_last && (i == nbeats - 1));
            if (i == L - 1 && nbeats > L) begin
                check({name, "_len_at_overrun"}, 608'(err_len), 608'(1));
                check({name, "_busy_drain"}, 608'(busy), 608'(1));
            end
        end
        if (commit) begin
            for (int k = 0; k < N_CONS; k++) exp_cons[k] = base + 32'(k + 1);
            exp_ctrl = {w20, w19};
            exp_gen  = exp_gen + 8'd1;
        end
        // Between edge E (last beat) and E+1
        check({name, "_gen_before_commit"}, 608'(cfg_gen), 608'(gen_before));
        check({name, "_ready_after_last"}, 608'(cfg_if.cfg_ready), 608'(!commit));
        check({name, "_err_len"}, 608'(err_len), 608'(elen));
        check({name, "_err_rsv"}, 608'(err_rsv), 608'(ersv));
        check({name, "_err_chk"}, 608'(err_chk), 608'(0));
        @(negedge clk);
        // After edge E+1
        check({name, "_gen"}, 608'(cfg_gen), 608'(exp_gen));
        check({name, "_cons"}, cons_o, exp_cons_flat());
        check({name, "_ctrl"}, 608'(ctrl_o), 608'(exp_ctrl));
        check({name, "_ready_idle"}, 608'(cfg_if.cfg_ready), 608'(1));
        check({name, "_busy_idle"}, 608'(busy), 608'(0));
    endtask

    task automatic clear_errs(input string name);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check({name, "_clr_len"}, 608'(err_len), 608'(0));
        check({name, "_clr_rsv"}, 608'(err_rsv), 608'(0));
        check({name, "_clr_chk"}, 608'(err_chk), 608'(0));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_cons"}, cons_o, 608'(0));
        check({name, "_ctrl"}, 608'(ctrl_o), 608'(0));
        check({name, "_gen"}, 608'(cfg_gen), 608'(0));
        check({name, "_ready"}, 608'(cfg_if.cfg_ready), 608'(1));
        check({name, "_busy"}, 608'(busy), 608'(0));
        check({name, "_errs"}, 608'({err_len, err_rsv, err_chk}), 608'(0));
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        cfg_if.cfg_last  = 1'b0;
        for (int k = 0; k < N_CONS; k++) exp_cons[k] = '0;
        exp_ctrl = '0;
        exp_gen  = '0;

        vecs[0] = '{"clean_a", L,  32'h100, 32'h0000_0001, 32'h0055_0000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"clean_b", L,  32'h200, 32'hDEAD_BEEF, 32'h00FF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"short",   10, 32'h300, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"long",    25, 32'h400, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{"rsv",     L,  32'h500, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{"single",  1,  32'h600, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};

        // Reset
        repeat (3) @(negedge clk);
        check_reset_state("reset_held");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_state("reset_released");

        // Table of image scenarios
        for (int v = 0; v < 6; v++) begin
            send_image(vecs[v].name, vecs[v].nbeats, vecs[v].base, vecs[v].w19, vecs[v].w20,
                       1'b0, vecs[v].commit, vecs[v].elen, vecs[v].ersv);
            if (v == 0) begin
                check("clean_a_cons1", 608'(cons_o[31:0]), 608'(32'h101));
                check("clean_a_cons19", 608'(cons_o[607:576]), 608'(32'h113));
                check("clean_a_sel1", 608'(ctrl_o[0]), 608'(1));
                check("clean_a_relops", 608'({ctrl_o[55:54], ctrl_o[53:52], ctrl_o[51:50]}), 608'(6'b01_01_01));
            end
            if (vecs[v].elen || vecs[v].ersv) clear_errs(vecs[v].name);
        end

        // New reserved error on the same edge as err_clr: the error wins
        send_image("rsv_first", L, 32'h700, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        send_image("rsv_vs_clr", L, 32'h800, 32'h0, 32'h0100_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        clear_errs("rsv_vs_clr");

        // Reset in the middle of an image
        for (int i = 0; i < 12; i++) put_beat(32'h900 + 32'(i), 1'b0, 1'b0);
        check("midload_busy", 608'(busy), 608'(1));
        reset_n = 1'b0;
        #1;
        check_reset_state("midload_reset");
        for (int k = 0; k < N_CONS; k++) exp_cons[k] = '0;
        exp_ctrl = '0;
        exp_gen  = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_image("after_reset", L, 32'hA00, 32'h0000_0002, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check("after_reset_gen1", 608'(cfg_gen), 608'(1));

        // 255 further clean commits take cfg_gen from 1 through 255 to 0
        for (int n = 0; n < 255; n++) begin
            send_image("wrap", L, 32'(n) << 8, 32'(n), 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("gen_wrap_zero", 608'(cfg_gen), 608'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
